// File: rtl/vending_ctrl_param.sv
// Parametrised coin-credit vending controller with serial change engine.
// Credit accumulates in 5-units against PRICE_UNITS; overpayment and cancel
// refunds are paid out one change pulse per cycle while busy_o is high.
// Optional feature macro: CHG10_EN (pay 10-unit pulses first when defined).
module vending_ctrl_param #(
  parameter int unsigned PRICE_UNITS = 4,
  parameter int unsigned CREDIT_W    = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [1:0]          coin_i,
  input  logic                cancel_i,
  output logic                dispense_o,
  output logic                chg5_o,
  output logic                chg10_o,
  output logic                busy_o,
  output logic                coin_rej_o,
  output logic [CREDIT_W-1:0] credit_o
);

  typedef enum logic [0:0] {StAccum, StPayout} state_e;

  localparam logic [CREDIT_W:0]   PriceW = PRICE_UNITS[CREDIT_W:0];
  localparam logic [CREDIT_W-1:0] RemOne = CREDIT_W'(1);
`ifdef CHG10_EN
  localparam logic [CREDIT_W-1:0] RemTwo = CREDIT_W'(2);
`endif

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic                dispense_q, dispense_d;
  logic                chg5_q, chg5_d;
  logic                busy_q, busy_d;
  logic                coin_rej_q, coin_rej_d;
`ifdef CHG10_EN
  logic                chg10_q, chg10_d;
`endif

  logic [CREDIT_W:0]   coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W:0]   diff;
  logic                accept;

  // Decode the coin code into credit units.
  always_comb begin
    coin_val = '0;
    unique case (coin_i)
      2'b00:   coin_val[2:0] = 3'd0;
      2'b01:   coin_val[2:0] = 3'd1;
      2'b10:   coin_val[2:0] = 3'd2;
      default: coin_val[2:0] = 3'd5;
    endcase
  end

  assign sum  = {1'b0, credit_q} + coin_val;
  assign diff = sum - PriceW;

  // Next-state, credit, change counter and output pulse decisions.
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    rem_d      = rem_q;
    dispense_d = 1'b0;
    chg5_d     = 1'b0;
    coin_rej_d = 1'b0;
`ifdef CHG10_EN
    chg10_d    = 1'b0;
`endif
    accept     = 1'b0;

    unique case (state_q)
      StAccum: begin
        accept = 1'b1;
      end
      StPayout: begin
        if (rem_q != '0) begin
`ifdef CHG10_EN
          if (rem_q >= RemTwo) begin
            chg10_d = 1'b1;
            rem_d   = rem_q - RemTwo;
          end else begin
            chg5_d = 1'b1;
            rem_d  = rem_q - RemOne;
          end
`else
          chg5_d = 1'b1;
          rem_d  = rem_q - RemOne;
`endif
          // Coins during payout are returned by the acceptor, never credited.
          if (coin_i != 2'b00) begin
            coin_rej_d = 1'b1;
          end
        end else begin
          // Exit cycle: busy falls here and this edge may already take a coin.
          state_d = StAccum;
          accept  = 1'b1;
        end
      end
      default: begin
        state_d = StAccum;
      end
    endcase

    if (accept) begin
      if (coin_i != 2'b00) begin
        if (sum >= PriceW) begin
          // Vend wins over a simultaneous cancel; only the overpayment returns.
          dispense_d = 1'b1;
          credit_d   = '0;
          rem_d      = diff[CREDIT_W-1:0];
          state_d    = (diff != '0) ? StPayout : StAccum;
        end else if (cancel_i) begin
          // Coin is credited first, then the whole sum is refunded.
          credit_d = '0;
          rem_d    = sum[CREDIT_W-1:0];
          state_d  = StPayout;
        end else begin
          credit_d = sum[CREDIT_W-1:0];
        end
      end else if (cancel_i && (credit_q != '0)) begin
        rem_d    = credit_q;
        credit_d = '0;
        state_d  = StPayout;
      end
    end

    busy_d = (state_d == StPayout);
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StAccum;
      credit_q   <= '0;
      rem_q      <= '0;
      dispense_q <= 1'b0;
      chg5_q     <= 1'b0;
      busy_q     <= 1'b0;
      coin_rej_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      rem_q      <= rem_d;
      dispense_q <= dispense_d;
      chg5_q     <= chg5_d;
      busy_q     <= busy_d;
      coin_rej_q <= coin_rej_d;
    end
  end

`ifdef CHG10_EN
  // 10-unit change pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chg10_q <= 1'b0;
    end else begin
      chg10_q <= chg10_d;
    end
  end

  assign chg10_o = chg10_q;
`else
  assign chg10_o = 1'b0;
`endif

  assign dispense_o = dispense_q;
  assign chg5_o     = chg5_q;
  assign busy_o     = busy_q;
  assign coin_rej_o = coin_rej_q;
  assign credit_o   = credit_q;

endmodule
